// File: rtl/imem_pkg.sv
// Shared types and helpers for the boot-loaded instruction memory.
// Holds the sequencer state enum, the NOP word and the word-index helper.
package imem_pkg;

   typedef enum logic [1:0] {
      CLEAR,
      LOAD,
      RUN
   } imem_state_t;

   localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

   function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
      return {2'b00, byte_addr[31:2]};
   endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 instruction storage: one synchronous write port and one
// asynchronous read port; no reset on the contents.
module imem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction memory with clear/load/run boot sequencer and fetch port.
// Define IMEM_RELOAD_EN to add the reload_req port (re-boot from RUN).
module imem_boot_loader
   import imem_pkg::*;
#(
   parameter int          DEPTH     = 64,
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] FILL_WORD = IMEM_NOP
) (
   input  logic                     clk,
   input  logic                     reset,
`ifdef IMEM_RELOAD_EN
   input  logic                     reload_req,
`endif
   input  logic                     load_valid,
   input  logic [31:0]              load_data,
   input  logic                     load_last,
   output logic                     load_ready,
   input  logic [ADDR_W-1:0]        pc,
   output logic [31:0]              instruction,
   output logic                     imem_ready,
   output logic                     misaligned,
   output logic                     out_of_range,
   output logic [$clog2(DEPTH+1)-1:0] load_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   imem_state_t   state_q, state_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          we;
   logic [31:0]   wdata;
   logic [31:0]   rdata;
   logic [31:0]   idx;
   logic          run;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CLEAR;
         wptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wptr_d     = wptr_q;
      cnt_d      = cnt_q;
      we         = 1'b0;
      wdata      = FILL_WORD;
      load_ready = 1'b0;
      imem_ready = 1'b0;
      unique case (state_q)
         CLEAR: begin
            we     = 1'b1;
            wptr_d = wptr_q + AW'(1);
            if (wptr_q == LAST) begin
               state_d = LOAD;
               wptr_d  = '0;
               cnt_d   = '0;
            end
         end
         LOAD: begin
            load_ready = 1'b1;
            if (load_valid) begin
               we     = 1'b1;
               wdata  = load_data;
               wptr_d = wptr_q + AW'(1);
               cnt_d  = cnt_q + CW'(1);
               // Filling the last word ends the image even without load_last.
               if (load_last || wptr_q == LAST) begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            imem_ready = 1'b1;
`ifdef IMEM_RELOAD_EN
            if (reload_req) begin
               state_d = CLEAR;
               wptr_d  = '0;
            end
`endif
         end
         default: begin
            state_d = CLEAR;
            wptr_d  = '0;
         end
      endcase
   end

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (we),
      .waddr (wptr_q),
      .wdata (wdata),
      .raddr (idx[AW-1:0]),
      .rdata (rdata)
   );

   assign idx          = word_index(32'(pc));
   assign run          = (state_q == RUN);
   assign misaligned   = run && (pc[1:0] != 2'b00);
   assign out_of_range = run && (idx >= 32'(DEPTH));
   assign instruction  = (run && !misaligned && !out_of_range) ?
                         rdata : FILL_WORD;
   assign load_count   = cnt_q;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Parametrised, word-addressed instruction memory with a built-in boot-load sequencer, replacing hard-coded program images in the single-cycle core. After reset it clears the array, then accepts a program image over a valid/ready stream, then serves the core's combinational fetch port. The core's PC drives the fetch port directly; `imem_ready` gates the core's PC update until the image is resident.

## Interface
- `DEPTH`, 64: number of 32-bit words; power of two, 4..1024.
- `ADDR_W`, 8: byte-address width of `pc`; must satisfy 2^(ADDR_W-2) >= DEPTH.
- `FILL_WORD`, 32'h0000_0000: value written to every word during CLEAR; this is also the NOP value.
- `clk` input 1: rising-edge clock.
- `reset` input 1: reset, asynchronous, active-high.
- `load_valid` input 1: loader word valid.
- `load_data` input 32: instruction word, loaded in address order from word 0.
- `load_last` input 1: marks the final word of the image.
- `load_ready` output 1: block accepts a word this cycle.
- `pc` input ADDR_W: byte address from the core.
- `instruction` output 32: fetched word.
- `imem_ready` output 1: image resident, fetch valid.
- `misaligned` output 1: `pc[1:0]` != 0 while in RUN.
- `out_of_range` output 1: word index `pc[ADDR_W-1:2]` >= DEPTH while in RUN.
- `load_count` output $clog2(DEPTH+1): number of words accepted in the last load.
- `reload_req` input 1: present only with IMEM_RELOAD_EN.

## Operation
- FSM states: CLEAR, LOAD, RUN.
- CLEAR: writes FILL_WORD to word `wptr` each cycle, with `wptr` running 0..DEPTH-1. At `wptr`==DEPTH-1 the FSM goes to LOAD with `wptr` reset to 0 and `load_count` reset to 0.
- LOAD: `load_ready`=1. On a cycle with `load_valid`&&`load_ready`, `load_data` is written to word `wptr`, then `wptr` and `load_count` increment.
  - The FSM goes to RUN after an accepted word with `load_last`=1, or after accepting word DEPTH-1 (implicit last; later words are never accepted).
  - `load_valid`=0 stalls the FSM indefinitely with no timeout.
- RUN: `load_ready`=0 and `imem_ready`=1. `instruction` = mem[`pc[ADDR_W-1:2]`] combinationally.
- Fetch outputs are combinational in every state:
  - `misaligned` or `out_of_range` forces `instruction`=FILL_WORD. The flags are combinational from `pc`. When both apply, both flags assert.
  - Outside RUN, `instruction`=FILL_WORD and both flags are 0.
- Words not written during LOAD keep FILL_WORD.
- `load_count` updates only in LOAD and holds through RUN.

## Timing
- Reset values: state CLEAR, `wptr` 0, `load_count` 0, `load_ready` 0, `imem_ready` 0, `misaligned` 0, `out_of_range` 0, `instruction` FILL_WORD. Array contents are unspecified until CLEAR completes.
- Reset asserted mid-LOAD or mid-RUN returns the FSM to CLEAR, and the full clear repeats.
- CLEAR lasts exactly DEPTH cycles after reset deassertion. `load_ready` rises on cycle DEPTH+1.
- Load write latency: a word accepted at edge N is visible on `instruction` once RUN is entered.
- `imem_ready` rises in the cycle after the edge that accepted the last word. Minimum reset-to-ready time is DEPTH+1 accept cycles for a one-word image.
- Fetch latency in RUN: 0 cycles (combinational from `pc`).

## Configuration
- `IMEM_RELOAD_EN` defined:
  - Adds input `reload_req`. A `reload_req`=1 sampled in RUN moves the FSM to CLEAR on the next edge: `imem_ready` drops and a full clear and load follow.
  - `reload_req` is ignored in CLEAR and LOAD.
- `IMEM_RELOAD_EN` undefined:
  - The port does not exist. RUN is left only by `reset`.

## Structure
- Package `imem_pkg` holds:
  - the state enum `imem_state_t` {CLEAR, LOAD, RUN};
  - the default NOP constant `IMEM_NOP` = 32'h0;
  - the word-index helper function.
- Sub-module `imem_array`:
  - DEPTH x 32 storage with one synchronous write port (`we`, `waddr`, `wdata`) and one asynchronous read port.
  - No reset on the array.
- The top level holds the FSM, the pointers, and the flag/mux logic.

## Test plan
All scenarios use DEPTH=64, ADDR_W=8.

1. Reset, then a 5-word load (0x20080020, 0x20090037, 0x01098024, 0x01098025, 0xAC100004, last on word 4):
   - `load_ready` rises on cycle 65;
   - `imem_ready` is 1 one cycle after the 5th accept;
   - `pc`=0x08 -> 0x01098024;
   - `pc`=0x14 -> 0x00000000;
   - `load_count`=5.
2. `load_valid` toggled every other cycle during LOAD: only valid&&ready cycles write; the words land in order with no gaps or duplicates.
3. 70 words streamed with no `load_last`:
   - 64 are accepted;
   - RUN is entered after word 63;
   - `load_ready`=0 for words 64..69;
   - `load_count`=64;
   - `pc`=0xFC returns word 63.
4. In RUN:
   - `pc`=0x06 -> `misaligned`=1, `instruction`=0;
   - `pc` with word index 64 (0x100 with ADDR_W=9) -> `out_of_range`=1, `instruction`=0.
5. Reset asserted after 3 of 5 words:
   - outputs return to reset values immediately;
   - after CLEAR and a 2-word reload, `pc`=0x08 returns 0, not the old word.
6. With `IMEM_RELOAD_EN`:
   - a `reload_req` pulse in RUN -> `imem_ready`=0 on the next cycle, 64 CLEAR cycles follow, then `load_ready`=1;
   - `reload_req` held during LOAD has no effect.
